board_state: RTL and testbench



---
 rtl/board_state.sv | 175 +++++++++++++++++
 tb/tb_board_state.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state.sv
// board_state: 22x12 Tetris playfield with piece lock, line clear, line/score counters and game-over.
// Optional BOARD_SCORE_EN adds the score register; without it score is tied to zero.
module board_state #(
  parameter int SPAWN_ROW = 1,
  parameter int SCAN_TOP  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_game,
  input  logic              lock_req,
  input  logic [3:0][3:0]   shape,
  input  logic [4:0]        row_in,
  input  logic [3:0]        col_in,
  output logic [21:0][11:0] board_rows,
  output logic              busy,
  output logic              done,
  output logic [2:0]        lines_cleared,
  output logic [15:0]       lines_total,
  output logic [15:0]       score,
  output logic              game_over
);

  localparam logic [11:0] ROW_EMPTY = 12'h801;
  localparam logic [11:0] ROW_FLOOR = 12'hFFF;
  localparam logic [4:0]  TOP_ROW   = 5'(SCAN_TOP);
  localparam logic [4:0]  SPAWN     = 5'(SPAWN_ROW);

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0][3:0]   shape_q;
  logic [4:0]        row_q;
  logic [3:0]        col_q;
  logic [4:0]        s_q, s_nxt;
  logic [2:0]        cnt_q, cnt_nxt;
  logic [21:0][11:0] board_q, board_nxt;
  logic              gov_q, gov_nxt;
  logic [2:0]        lines_cleared_q;
  logic [15:0]       lines_total_q;
  logic [16:0]       total_sum;
  logic              row_full, above_full;

  function automatic logic [21:0][11:0] empty_board();
    logic [21:0][11:0] b;
    for (int k = 0; k < 22; k++) b[k] = ROW_EMPTY;
    b[21] = ROW_FLOOR;
    return b;
  endfunction

  assign row_full   = &board_q[s_q][10:1];
  assign above_full = &board_q[s_q - 5'd1][10:1];
  assign total_sum  = {1'b0, lines_total_q} + 17'(cnt_nxt);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    s_nxt     = s_q;
    cnt_nxt   = cnt_q;
    board_nxt = board_q;
    gov_nxt   = gov_q;
    unique case (state)
      IDLE: if (lock_req) state_nxt = LOCK;
      LOCK: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            if (shape_q[r][c] && (int'(row_q) + r <= 21) && (int'(col_q) + c <= 11))
              board_nxt[row_q + 5'(r)][col_q + 4'(c)] = 1'b1;
          end
        end
        if (row_q == SPAWN) gov_nxt = 1'b1;
        s_nxt     = 5'd20;
        cnt_nxt   = '0;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (row_full)             state_nxt = SHIFT;
        else if (s_q == TOP_ROW)  state_nxt = DONE;
        else                      s_nxt = s_q - 5'd1;
      end
      SHIFT: begin
        for (int k = 1; k < 22; k++) begin
          if (k > SCAN_TOP && k <= int'(s_q)) board_nxt[k] = board_q[k-1];
        end
        board_nxt[TOP_ROW] = ROW_EMPTY;
        cnt_nxt = cnt_q + 3'd1;
        // Look ahead at the row dropping into s, so each clear costs a single cycle.
        if (s_q == TOP_ROW)   state_nxt = DONE;
        else if (above_full)  state_nxt = SHIFT;
        else begin
          s_nxt     = s_q - 5'd1;
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the board is a register file, so it resets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      board_q         <= empty_board();
      shape_q         <= '0;
      row_q           <= '0;
      col_q           <= '0;
      s_q             <= '0;
      cnt_q           <= '0;
      gov_q           <= 1'b0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
    end else if (new_game) begin
      state           <= IDLE;
      board_q         <= empty_board();
      shape_q         <= '0;
      row_q           <= '0;
      col_q           <= '0;
      s_q             <= '0;
      cnt_q           <= '0;
      gov_q           <= 1'b0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
    end else begin
      state   <= state_nxt;
      board_q <= board_nxt;
      s_q     <= s_nxt;
      cnt_q   <= cnt_nxt;
      gov_q   <= gov_nxt;
      if (state == IDLE && lock_req) begin
        shape_q <= shape;
        row_q   <= row_in;
        col_q   <= col_in;
      end
      if (state_nxt == DONE) begin
        lines_cleared_q <= cnt_nxt;
        lines_total_q   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
    end
  end

`ifdef BOARD_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  function automatic logic [15:0] points(input logic [2:0] n);
    case (n)
      3'd1:    return 16'd40;
      3'd2:    return 16'd100;
      3'd3:    return 16'd300;
      3'd4:    return 16'd1200;
      default: return 16'd0;
    endcase
  endfunction

  assign score_sum = {1'b0, score_q} + {1'b0, points(cnt_nxt)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     score_q <= '0;
    else if (new_game)             score_q <= '0;
    else if (state_nxt == DONE)    score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign board_rows    = board_q;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign lines_cleared = lines_cleared_q;
  assign lines_total   = lines_total_q;
  assign game_over     = gov_q;

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: directed locks push expectations, a negedge monitor checks each done pulse.
module tb_board_state;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              new_game = 1'b0;
  logic              lock_req = 1'b0;
  logic [3:0][3:0]   shape = '0;
  logic [4:0]        row_in = '0;
  logic [3:0]        col_in = '0;
  logic [21:0][11:0] board_rows;
  logic              busy, done, game_over;
  logic [2:0]        lines_cleared;
  logic [15:0]       lines_total, score;

  board_state dut (
    .clk(clk), .reset(reset), .new_game(new_game), .lock_req(lock_req),
    .shape(shape), .row_in(row_in), .col_in(col_in),
    .board_rows(board_rows), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .lines_total(lines_total),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                issue;
    int                lat;
    logic [2:0]        lc;
    logic [15:0]       lt;
    logic [15:0]       sc;
    logic              gov;
    logic [21:0][11:0] rows;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_board(input string name, input logic [21:0][11:0] exp);
    int bad;
    bad = -1;
    for (int k = 21; k >= 0; k--) if (board_rows[k] !== exp[k]) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: row %0d got %h expected %h (t=%0t)", name, bad, board_rows[bad], exp[bad], $time);
    end
  endtask

  function automatic logic [21:0][11:0] empty_board();
    logic [21:0][11:0] b;
    for (int k = 0; k < 21; k++) b[k] = 12'h801;
    b[21] = 12'hFFF;
    return b;
  endfunction

  function automatic logic [15:0] exp_sc(input logic [15:0] v);
`ifdef BOARD_SCORE_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  function automatic exp_t mk(input int lat, input logic [2:0] lc, input logic [15:0] lt,
                              input logic [15:0] sc, input logic gov, input logic [21:0][11:0] rows);
    exp_t e;
    e.issue = 0; e.lat = lat; e.lc = lc; e.lt = lt; e.sc = sc; e.gov = gov; e.rows = rows;
    return e;
  endfunction

  // Cycle n is the clock period that ends at edge n; lock_req is sampled at edge 0.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending sequence (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc - mon_e.issue + 1, mon_e.lat);
        check("lines_cleared", lines_cleared, mon_e.lc);
        check("lines_total", lines_total, mon_e.lt);
        check("score", score, mon_e.sc);
        check("game_over", game_over, mon_e.gov);
        check("busy_at_done", busy, 1);
        check_board("board_at_done", mon_e.rows);
      end
    end
  end

  task automatic pulse_lock(input logic [15:0] shp, input int row, input int col, output int issue);
    @(negedge clk);
    lock_req = 1'b1;
    shape    = shp;
    row_in   = 5'(row);
    col_in   = 4'(col);
    issue    = cyc + 1;
    @(negedge clk);
    lock_req = 1'b0;
  endtask

  task automatic lock(input logic [15:0] shp, input int row, input int col, input exp_t e);
    int issue;
    exp_t q;
    q = e;
    fork
      pulse_lock(shp, row, col, issue);
      begin
        @(negedge clk);
        q.issue = cyc + 1;
        sb.push_back(q);
      end
    join
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sequence_completes", (n < 100), 1);
    if (n >= 100) sb.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0][11:0] b;
    int dummy;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_board("reset_board", empty_board());
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_lines_cleared", lines_cleared, 0);
    check("reset_lines_total", lines_total, 0);
    check("reset_score", score, 0);
    check("reset_game_over", game_over, 0);

    // O piece at the bottom, no clear
    b = empty_board(); b[19] = 12'h861; b[20] = 12'h861;
    lock(16'h0033, 19, 5, mk(22, 0, 0, 0, 0, b));
    wait_done();

    pulse_new_game();
    check_board("new_game_board", empty_board());

    // Build row 20 = F7F, then drop a vertical I into column 7
    b = empty_board(); b[20] = 12'h861;
    lock(16'h0003, 20, 5, mk(22, 0, 0, 0, 0, b));
    wait_done();
    b[20] = 12'hF61;
    lock(16'h0007, 20, 8, mk(22, 0, 0, 0, 0, b));
    wait_done();
    b[20] = 12'hF7F;
    lock(16'h000F, 20, 1, mk(22, 0, 0, 0, 0, b));
    wait_done();
    b = empty_board(); b[18] = 12'h881; b[19] = 12'h881; b[20] = 12'h881;
    lock(16'h1111, 17, 7, mk(23, 1, 1, exp_sc(16'd40), 0, b));
    wait_done();

    // Tetris: rows 17-20 full except column 10
    pulse_new_game();
    b = empty_board(); for (int k = 17; k <= 20; k++) b[k] = 12'h81F;
    lock(16'hFFFF, 17, 1, mk(22, 0, 0, 0, 0, b));
    wait_done();
    for (int k = 17; k <= 20; k++) b[k] = 12'h9FF;
    lock(16'hFFFF, 17, 5, mk(22, 0, 0, 0, 0, b));
    wait_done();
    for (int k = 17; k <= 20; k++) b[k] = 12'hBFF;
    lock(16'h1111, 17, 9, mk(22, 0, 0, 0, 0, b));
    wait_done();
    lock(16'h1111, 17, 10, mk(26, 4, 4, exp_sc(16'd1200), 0, empty_board()));
    wait_done();

    // Asynchronous reset in the middle of a sequence
    pulse_lock(16'h0033, 19, 5, dummy);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midseq_reset_busy", busy, 0);
    check("midseq_reset_row5", board_rows[5], 12'h801);
    check("midseq_reset_row21", board_rows[21], 12'hFFF);
    check_board("midseq_reset_board", empty_board());
    check("midseq_reset_lines_total", lines_total, 0);
    check("midseq_reset_score", score, 0);
    check("midseq_reset_lines_cleared", lines_cleared, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;

    // Lock at the spawn row sets sticky game_over
    b = empty_board(); b[1] = 12'h861; b[2] = 12'h861;
    lock(16'h0033, 1, 5, mk(22, 0, 0, 0, 1, b));
    wait_done();
    b[19] = 12'h807; b[20] = 12'h807;
    lock(16'h0033, 19, 1, mk(22, 0, 0, 0, 1, b));
    wait_done();
    check("game_over_sticky", game_over, 1);
    pulse_new_game();
    check("game_over_cleared", game_over, 0);

    // lock_req while busy is ignored
    b = empty_board(); b[19] = 12'h861; b[20] = 12'h861;
    lock(16'h0033, 19, 5, mk(22, 0, 0, 0, 0, b));
    repeat (3) @(negedge clk);
    pulse_lock(16'hFFFF, 10, 1, dummy);
    wait_done();
    repeat (25) @(negedge clk);
    check_board("busy_lock_ignored", b);

    // new_game beats a simultaneous lock_req
    @(negedge clk);
    new_game = 1'b1; lock_req = 1'b1; shape = 16'hFFFF; row_in = 5'd10; col_in = 4'd1;
    @(negedge clk);
    new_game = 1'b0; lock_req = 1'b0;
    check_board("new_game_vs_lock_board", empty_board());
    check("new_game_vs_lock_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("new_game_vs_lock_still_idle", busy, 0);
    check_board("new_game_vs_lock_board_later", empty_board());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
